// File: rtl/bsg_global_buffer_pkg.sv
// Shared types for the global buffer tile: bank grant encoding and the write-queue entry declare macro.
`ifndef BSG_GLOBAL_BUFFER_PKG_SV
`define BSG_GLOBAL_BUFFER_PKG_SV

// The entry width depends on the bank geometry, so each user declares it locally.
`define BSG_GB_WO_ENTRY_S_DECLARE(addr_width_mp, data_width_mp) \
  typedef struct packed { \
    logic [addr_width_mp-1:0] addr; \
    logic [data_width_mp-1:0] data; \
  } bsg_gb_wo_entry_s

package bsg_global_buffer_pkg;

  typedef enum logic [1:0] {
    e_grant_none = 2'd0,
    e_grant_ro   = 2'd1,
    e_grant_wo   = 2'd2,
    e_grant_rw   = 2'd3
  } bsg_gb_grant_e;

  function automatic int unsigned bsg_gb_safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

`endif

// File: rtl/bsg_global_buffer_bank_sched_if.sv
// Request/response and bank-port bundle of the global buffer bank scheduler.
interface bsg_global_buffer_bank_sched_if #(
  parameter int data_width_p = 8,
  parameter int addr_width_p = 4
);
  logic                    ro_v_i;
  logic [addr_width_p-1:0] ro_addr_i;
  logic                    ro_data_v_o;
  logic [data_width_p-1:0] ro_data_o;

  logic                    wo_v_i;
  logic [addr_width_p-1:0] wo_addr_i;
  logic [data_width_p-1:0] wo_data_i;
  logic                    wo_ready_o;

  logic                    rw_v_i;
  logic                    rw_w_i;
  logic [addr_width_p-1:0] rw_addr_i;
  logic [data_width_p-1:0] rw_data_i;
  logic                    rw_yumi_o;
  logic                    rw_data_v_o;
  logic [data_width_p-1:0] rw_data_o;

  logic                    mem_v_o;
  logic                    mem_w_o;
  logic [addr_width_p-1:0] mem_addr_o;
  logic [data_width_p-1:0] mem_data_o;
  logic [data_width_p-1:0] mem_data_i;

  // master: requesters plus the bank; slave: the scheduler
  modport master (
    output ro_v_i, ro_addr_i, wo_v_i, wo_addr_i, wo_data_i,
           rw_v_i, rw_w_i, rw_addr_i, rw_data_i, mem_data_i,
    input  ro_data_v_o, ro_data_o, wo_ready_o, rw_yumi_o, rw_data_v_o, rw_data_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  ro_v_i, ro_addr_i, wo_v_i, wo_addr_i, wo_data_i,
           rw_v_i, rw_w_i, rw_addr_i, rw_data_i, mem_data_i,
    output ro_data_v_o, ro_data_o, wo_ready_o, rw_yumi_o, rw_data_v_o, rw_data_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/bsg_global_buffer_bank_sched_wq.sv
// Circular write queue for the wo stream; pointers/count reset asynchronously, storage is not reset.
module bsg_global_buffer_bank_sched_wq
  import bsg_global_buffer_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_v_i,
  input  logic [width_p-1:0] enq_data_i,
  input  logic               deq_v_i,
  output logic [width_p-1:0] head_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int ptr_w_lp = bsg_gb_safe_clog2(els_p);
  localparam int cnt_w_lp = bsg_gb_safe_clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  assign full_o  = (count_r == full_cnt_lp);
  assign empty_o = (count_r == '0);
  assign enq     = enq_v_i & ~full_o;
  assign deq     = deq_v_i & ~empty_o;
  assign head_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + ptr_w_lp'(1);
      if (deq) rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + ptr_w_lp'(1);
      if (enq && !deq)      count_r <= count_r + cnt_w_lp'(1);
      else if (deq && !enq) count_r <= count_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= enq_data_i;
  end

endmodule

// File: rtl/bsg_global_buffer_bank_sched.sv
// Single-port bank scheduler: ro > (starved rw) > queued wo > rw.
// Optional rw age guard compiled in with BSG_GB_BANK_SCHED_STARVE_GUARD_EN.
module bsg_global_buffer_bank_sched
  import bsg_global_buffer_pkg::*;
#(
  parameter int data_width_p   = 8,
  parameter int bank_els_p     = 16,
  parameter int wo_fifo_els_p  = 4,
  parameter int starve_limit_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  bsg_global_buffer_bank_sched_if.slave  bus
);
  localparam int bank_addr_width_lp = bsg_gb_safe_clog2(bank_els_p);

  `BSG_GB_WO_ENTRY_S_DECLARE(bank_addr_width_lp, data_width_p);

  bsg_gb_wo_entry_s              enq_entry, head_entry;
  bsg_gb_grant_e                 grant_p0;
  logic                          wq_empty, wq_full;
  logic                          starved;
  logic                          rw_yumi;
  logic                          mem_v, mem_w;
  logic [bank_addr_width_lp-1:0] mem_addr;
  logic [data_width_p-1:0]       mem_data;
  logic                          ro_vld_p1, rw_vld_p1;

  assign enq_entry.addr = bus.wo_addr_i;
  assign enq_entry.data = bus.wo_data_i;

  bsg_global_buffer_bank_sched_wq #(
    .els_p   (wo_fifo_els_p),
    .width_p ($bits(bsg_gb_wo_entry_s))
  ) wq (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enq_v_i    (bus.wo_v_i),
    .enq_data_i (enq_entry),
    .deq_v_i    (grant_p0 == e_grant_wo),
    .head_o     (head_entry),
    .empty_o    (wq_empty),
    .full_o     (wq_full)
  );

`ifdef BSG_GB_BANK_SCHED_STARVE_GUARD_EN
  localparam int starve_w_lp = bsg_gb_safe_clog2(starve_limit_p + 1);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  logic [starve_w_lp-1:0] starve_cnt_r;

  assign starved = (starve_cnt_r == starve_max_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                     starve_cnt_r <= '0;
    else if (!bus.rw_v_i || rw_yumi)    starve_cnt_r <= '0;
    else if (!starved)                  starve_cnt_r <= starve_cnt_r + starve_w_lp'(1);
  end
`else
  assign starved = 1'b0;
`endif

  // stage p0: grant arbitration and bank port drive
  always_comb begin
    grant_p0 = e_grant_none;
    if (!reset_n_i)                   grant_p0 = e_grant_none;
    else if (bus.ro_v_i)              grant_p0 = e_grant_ro;
    else if (starved && bus.rw_v_i)   grant_p0 = e_grant_rw;
    else if (!wq_empty)               grant_p0 = e_grant_wo;
    else if (bus.rw_v_i)              grant_p0 = e_grant_rw;
  end

  always_comb begin
    mem_v    = 1'b0;
    mem_w    = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    unique case (grant_p0)
      e_grant_ro: begin
        mem_v    = 1'b1;
        mem_addr = bus.ro_addr_i;
      end
      e_grant_wo: begin
        mem_v    = 1'b1;
        mem_w    = 1'b1;
        mem_addr = head_entry.addr;
        mem_data = head_entry.data;
      end
      e_grant_rw: begin
        mem_v    = 1'b1;
        mem_w    = bus.rw_w_i;
        mem_addr = bus.rw_addr_i;
        mem_data = bus.rw_data_i;
      end
      default: ;
    endcase
  end

  assign rw_yumi        = (grant_p0 == e_grant_rw);
  assign bus.rw_yumi_o  = rw_yumi;
  assign bus.wo_ready_o = ~wq_full;
  assign bus.mem_v_o    = mem_v;
  assign bus.mem_w_o    = mem_w;
  assign bus.mem_addr_o = mem_addr;
  assign bus.mem_data_o = mem_data;

  // stage p1: one-cycle read response valids, aligned with bank read data
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ro_vld_p1 <= 1'b0;
      rw_vld_p1 <= 1'b0;
    end else begin
      ro_vld_p1 <= (grant_p0 == e_grant_ro);
      rw_vld_p1 <= (grant_p0 == e_grant_rw) & ~bus.rw_w_i;
    end
  end

  assign bus.ro_data_v_o = ro_vld_p1;
  assign bus.rw_data_v_o = rw_vld_p1;
  assign bus.ro_data_o   = reset_n_i ? bus.mem_data_i : '0;
  assign bus.rw_data_o   = reset_n_i ? bus.mem_data_i : '0;

endmodule

// File: tb/tb_bsg_global_buffer_bank_sched.sv
// Directed bench for bsg_global_buffer_bank_sched with a behavioural 1rw sync bank.
module tb_bsg_global_buffer_bank_sched;
  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  logic [7:0] bank [16];

  bsg_global_buffer_bank_sched_if #(.data_width_p(8), .addr_width_p(4)) bus ();

  bsg_global_buffer_bank_sched #(
    .data_width_p   (8),
    .bank_els_p     (16),
    .wo_fifo_els_p  (4),
    .starve_limit_p (8)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bank model: preloaded while reset is low
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) bank[i] <= 8'(i);
      bank[1] <= 8'h11;
      bank[3] <= 8'hA5;
      bank[4] <= 8'h44;
    end else if (bus.mem_v_o) begin
      if (bus.mem_w_o) bank[bus.mem_addr_o] <= bus.mem_data_o;
      else             bus.mem_data_i <= bank[bus.mem_addr_o];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    bus.mem_data_i = 8'h00;
    bus.ro_v_i     = 1'b1;
    bus.ro_addr_i  = 4'd3;
    bus.wo_v_i     = 1'b0;
    bus.wo_addr_i  = 4'd0;
    bus.wo_data_i  = 8'h00;
    bus.rw_v_i     = 1'b0;
    bus.rw_w_i     = 1'b0;
    bus.rw_addr_i  = 4'd0;
    bus.rw_data_i  = 8'h00;

    // reset state, with ro requesting
    mid();
    chk("rst_mem_v", 32'(bus.mem_v_o), 0);
    chk("rst_wo_ready", 32'(bus.wo_ready_o), 1);
    chk("rst_ro_data_v", 32'(bus.ro_data_v_o), 0);
    chk("rst_rw_data_v", 32'(bus.rw_data_v_o), 0);
    chk("rst_rw_yumi", 32'(bus.rw_yumi_o), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr_o), 0);
    step();
    step();
    reset_n    = 1'b1;
    bus.ro_v_i = 1'b0;
    mid();
    chk("idle_mem_v", 32'(bus.mem_v_o), 0);

    // ro only, addr 3
    step();
    bus.ro_v_i    = 1'b1;
    bus.ro_addr_i = 4'd3;
    mid();
    chk("ro_mem_v", 32'(bus.mem_v_o), 1);
    chk("ro_mem_w", 32'(bus.mem_w_o), 0);
    chk("ro_mem_addr", 32'(bus.mem_addr_o), 3);
    step();
    bus.ro_v_i = 1'b0;
    mid();
    chk("ro_data_v", 32'(bus.ro_data_v_o), 1);
    chk("ro_data", 32'(bus.ro_data_o), 32'hA5);
    chk("ro_rw_data_v", 32'(bus.rw_data_v_o), 0);

    // three-way collision
    step();
    bus.ro_v_i = 1'b1; bus.ro_addr_i = 4'd1;
    bus.wo_v_i = 1'b1; bus.wo_addr_i = 4'd2; bus.wo_data_i = 8'h55;
    bus.rw_v_i = 1'b1; bus.rw_w_i = 1'b0; bus.rw_addr_i = 4'd4;
    mid();
    chk("col_t_addr", 32'(bus.mem_addr_o), 1);
    chk("col_t_w", 32'(bus.mem_w_o), 0);
    chk("col_t_yumi", 32'(bus.rw_yumi_o), 0);
    step();
    bus.ro_v_i = 1'b0;
    bus.wo_v_i = 1'b0;
    mid();
    chk("col_t1_w", 32'(bus.mem_w_o), 1);
    chk("col_t1_addr", 32'(bus.mem_addr_o), 2);
    chk("col_t1_data", 32'(bus.mem_data_o), 32'h55);
    chk("col_t1_yumi", 32'(bus.rw_yumi_o), 0);
    chk("col_t1_ro_data_v", 32'(bus.ro_data_v_o), 1);
    chk("col_t1_ro_data", 32'(bus.ro_data_o), 32'h11);
    step();
    mid();
    chk("col_t2_addr", 32'(bus.mem_addr_o), 4);
    chk("col_t2_w", 32'(bus.mem_w_o), 0);
    chk("col_t2_yumi", 32'(bus.rw_yumi_o), 1);
    chk("col_t2_ro_data_v", 32'(bus.ro_data_v_o), 0);
    step();
    bus.rw_v_i = 1'b0;
    mid();
    chk("col_t3_rw_data_v", 32'(bus.rw_data_v_o), 1);
    chk("col_t3_rw_data", 32'(bus.rw_data_o), 32'h44);
    chk("col_t3_mem_v", 32'(bus.mem_v_o), 0);
    step();
    bus.ro_v_i = 1'b1; bus.ro_addr_i = 4'd2;
    step();
    bus.ro_v_i = 1'b0;
    mid();
    chk("col_readback", 32'(bus.ro_data_o), 32'h55);

    // ro held for 6 cycles, 5 writes offered into a 4-deep queue
    for (int c = 0; c < 6; c++) begin
      step();
      k = (c < 4) ? c : 4;
      bus.ro_v_i    = 1'b1;
      bus.ro_addr_i = 4'd0;
      bus.wo_v_i    = 1'b1;
      bus.wo_addr_i = 4'(8 + k);
      bus.wo_data_i = 8'(8'h80 + k);
      mid();
      chk("fill_ready", 32'(bus.wo_ready_o), (c < 4) ? 1 : 0);
      chk("fill_mem_w", 32'(bus.mem_w_o), 0);
    end
    step();
    bus.ro_v_i = 1'b0;
    bus.wo_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("drain_w", 32'(bus.mem_w_o), 1);
      chk("drain_addr", 32'(bus.mem_addr_o), 8 + i);
      chk("drain_data", 32'(bus.mem_data_o), 32'h80 + i);
      step();
    end
    mid();
    chk("drain_done_v", 32'(bus.mem_v_o), 0);
    chk("drain_ready", 32'(bus.wo_ready_o), 1);

    // continuous wo traffic with a pending rw write
    step();
    bus.wo_v_i = 1'b1; bus.wo_addr_i = 4'd9; bus.wo_data_i = 8'h00;
    mid();
    chk("nobypass_mem_v", 32'(bus.mem_v_o), 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.wo_data_i = 8'(c);
      bus.rw_v_i = 1'b1; bus.rw_w_i = 1'b1; bus.rw_addr_i = 4'd5; bus.rw_data_i = 8'h77;
      mid();
      chk("starve_yumi", 32'(bus.rw_yumi_o), 0);
      chk("starve_wo_addr", 32'(bus.mem_addr_o), 9);
    end
    step();
    bus.wo_data_i = 8'h09;
    mid();
`ifdef BSG_GB_BANK_SCHED_STARVE_GUARD_EN
    chk("guard_yumi", 32'(bus.rw_yumi_o), 1);
    chk("guard_addr", 32'(bus.mem_addr_o), 5);
    chk("guard_data", 32'(bus.mem_data_o), 32'h77);
    step();
    bus.rw_v_i = 1'b0;
    bus.wo_v_i = 1'b0;
    mid();
    chk("guard_after_yumi", 32'(bus.rw_yumi_o), 0);
    chk("guard_after_addr", 32'(bus.mem_addr_o), 9);
    step();
    mid();
    chk("guard_drain_v", 32'(bus.mem_v_o), 1);
    step();
    mid();
    chk("guard_idle_v", 32'(bus.mem_v_o), 0);
`else
    chk("noguard_yumi9", 32'(bus.rw_yumi_o), 0);
    chk("noguard_addr9", 32'(bus.mem_addr_o), 9);
    step();
    bus.wo_v_i = 1'b0;
    mid();
    chk("noguard_yumi10", 32'(bus.rw_yumi_o), 0);
    chk("noguard_w10", 32'(bus.mem_w_o), 1);
    step();
    mid();
    chk("noguard_yumi11", 32'(bus.rw_yumi_o), 1);
    chk("noguard_addr11", 32'(bus.mem_addr_o), 5);
    chk("noguard_data11", 32'(bus.mem_data_o), 32'h77);
    step();
    bus.rw_v_i = 1'b0;
    mid();
    chk("noguard_idle_v", 32'(bus.mem_v_o), 0);
`endif

    // reset mid-stream with three queued writes
    for (int c = 0; c < 3; c++) begin
      step();
      bus.ro_v_i = 1'b1; bus.ro_addr_i = 4'd0;
      bus.wo_v_i = 1'b1; bus.wo_addr_i = 4'd10; bus.wo_data_i = 8'(8'h31 + c);
      mid();
      chk("q3_ready", 32'(bus.wo_ready_o), 1);
    end
    step();
    bus.ro_v_i = 1'b0;
    bus.wo_v_i = 1'b0;
    reset_n    = 1'b0;
    mid();
    chk("midrst_mem_v", 32'(bus.mem_v_o), 0);
    chk("midrst_ro_data_v", 32'(bus.ro_data_v_o), 0);
    chk("midrst_ro_data", 32'(bus.ro_data_o), 0);
    chk("midrst_wo_ready", 32'(bus.wo_ready_o), 1);
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("postrst_mem_v", 32'(bus.mem_v_o), 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
